// File: rtl/plru_tree_controller_pkg.sv
// Shared defaults, derived widths and FSM states
// for the tree-PLRU replacement controller.
package plru_tree_controller_pkg;

    localparam int WAYS_DEF      = 4;
    localparam int SETS_DEF      = 64;
    localparam int ADDR_W_DEF    = 32;
    localparam int BLK_OFF_W_DEF = 5;

    localparam int INDEX_W = $clog2(SETS_DEF);
    localparam int WAY_W   = $clog2(WAYS_DEF);
    localparam int TREE_W  = WAYS_DEF - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/plru_tree_controller_logic.sv
// Combinational tree-PLRU kernel: promote a way in a tree,
// and pick a victim from a tree plus an invalid-way mask.
module plru_tree_logic
    import plru_tree_controller_pkg::*;
#(
    parameter int WAYS = WAYS_DEF
) (
    input  logic [WAYS-2:0]          tree_in,
    input  logic [$clog2(WAYS)-1:0]  acc_way,
    input  logic [WAYS-1:0]          inv_mask,
    output logic [WAYS-2:0]          tree_nxt,
    output logic [$clog2(WAYS)-1:0]  victim
);

    localparam int LW = $clog2(WAYS);
    localparam int NW = LW + 1;

    // node indices need one spare bit: the walk steps past the last node
    logic [NW-1:0] upd_node;
    logic [NW-1:0] vic_node;

    always_comb begin
        tree_nxt = tree_in;
        upd_node = '0;
        for (int l = LW - 1; l >= 0; l--) begin
            tree_nxt[upd_node[LW-1:0]] = ~acc_way[l];
            upd_node = (upd_node << 1) + NW'(1) + NW'(acc_way[l]);
        end
    end

    always_comb begin
        victim   = '0;
        vic_node = '0;
        if (|inv_mask) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (inv_mask[w]) begin
                    victim = LW'(w);
                end
            end
        end else begin
            for (int l = LW - 1; l >= 0; l--) begin
                victim[l] = tree_in[vic_node[LW-1:0]];
                vic_node  = (vic_node << 1) + NW'(1)
                          + NW'(tree_in[vic_node[LW-1:0]]);
            end
        end
    end

endmodule

// File: rtl/plru_tree_controller.sv
// Per-set tree-PLRU state with 1-cycle victim lookup,
// access updates with same-set bypass, and a flush sweep.
module plru_tree_controller
    import plru_tree_controller_pkg::*;
#(
    parameter int WAYS      = WAYS_DEF,
    parameter int SETS      = SETS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BLK_OFF_W = BLK_OFF_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lk_valid,
    input  logic [ADDR_W-1:0]         lk_addr,
    input  logic [WAYS-1:0]           lk_inv_mask,
    output logic                      victim_valid,
    output logic [$clog2(WAYS)-1:0]   victim_way,
    input  logic                      acc_valid,
    input  logic [ADDR_W-1:0]         acc_addr,
    input  logic [$clog2(WAYS)-1:0]   acc_way,
    input  logic                      flush_req,
    output logic                      busy
);

    localparam int SET_IW = $clog2(SETS);
    localparam int WAY_IW = $clog2(WAYS);
    localparam int NODE_W = WAYS - 1;

    logic [NODE_W-1:0] tree_q [SETS];
    logic [NODE_W-1:0] tree_d [SETS];

    state_e            state_q, state_d;
    logic [SET_IW-1:0] flush_cnt_q, flush_cnt_d;
    logic              victim_valid_q, victim_valid_d;
    logic [WAY_IW-1:0] victim_way_q, victim_way_d;

    logic [SET_IW-1:0] acc_idx;
    logic [SET_IW-1:0] lk_idx;
    logic              idle;
    logic              acc_en;
    logic              lk_en;
    logic [NODE_W-1:0] upd_tree;
    logic [NODE_W-1:0] lk_tree;
    logic [WAY_IW-1:0] lk_victim;

    logic [WAY_IW-1:0] unused_upd_victim;
    logic [NODE_W-1:0] unused_lk_tree;
    logic              unused_addr;

    assign acc_idx = acc_addr[BLK_OFF_W +: SET_IW];
    assign lk_idx  = lk_addr[BLK_OFF_W +: SET_IW];
    assign unused_addr = ^{acc_addr, lk_addr};

    assign idle   = (state_q == ST_IDLE);
    assign acc_en = acc_valid && idle && !flush_req;
    assign lk_en  = lk_valid && idle;

    plru_tree_logic #(
        .WAYS (WAYS)
    ) u_upd (
        .tree_in  (tree_q[acc_idx]),
        .acc_way  (acc_way),
        .inv_mask ('0),
        .tree_nxt (upd_tree),
        .victim   (unused_upd_victim)
    );

    // same-set access in the lookup cycle: walk the post-update tree
    assign lk_tree = (acc_en && (acc_idx == lk_idx))
                   ? upd_tree : tree_q[lk_idx];

    plru_tree_logic #(
        .WAYS (WAYS)
    ) u_lk (
        .tree_in  (lk_tree),
        .acc_way  ('0),
        .inv_mask (lk_inv_mask),
        .tree_nxt (unused_lk_tree),
        .victim   (lk_victim)
    );

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        tree_d         = tree_q;
        victim_valid_d = lk_en;
        victim_way_d   = lk_en ? lk_victim : victim_way_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (acc_valid) begin
                    tree_d[acc_idx] = upd_tree;
                end
            end
            ST_FLUSH: begin
                tree_d[flush_cnt_q] = '0;
                if (flush_cnt_q == SET_IW'(SETS - 1)) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + SET_IW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            tree_q         <= tree_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign busy         = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_plru_tree_controller.sv
// Directed checks for plru_tree_controller at WAYS=4, SETS=64,
// BLK_OFF_W=5: lookups, updates, bypass, flush and reset.
module tb_plru_tree_controller;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic [31:0] lk_addr;
    logic [3:0]  lk_inv_mask;
    logic        victim_valid;
    logic [1:0]  victim_way;
    logic        acc_valid;
    logic [31:0] acc_addr;
    logic [1:0]  acc_way;
    logic        flush_req;
    logic        busy;

    int checks;
    int errors;

    plru_tree_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lk_valid     (lk_valid),
        .lk_addr      (lk_addr),
        .lk_inv_mask  (lk_inv_mask),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .acc_valid    (acc_valid),
        .acc_addr     (acc_addr),
        .acc_way      (acc_way),
        .flush_req    (flush_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // offset and tag bits set so only bits [10:5] select the set
    function automatic logic [31:0] addr_of(input int set);
        return 32'hF000_0000 | (32'(set) << 5) | 32'h13;
    endfunction

    task automatic lookup(input int set, input logic [3:0] mask,
                          output logic v, output logic [1:0] w);
        @(negedge clk);
        lk_valid    = 1'b1;
        lk_addr     = addr_of(set);
        lk_inv_mask = mask;
        @(negedge clk);
        lk_valid    = 1'b0;
        lk_inv_mask = 4'b0;
        v = victim_valid;
        w = victim_way;
    endtask

    task automatic access(input int set, input logic [1:0] way);
        @(negedge clk);
        acc_valid = 1'b1;
        acc_addr  = addr_of(set);
        acc_way   = way;
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic v;
        logic [1:0] w;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || victim_valid !== 1'b0 || victim_way !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b vv=%b way=%0d expected 0 0 0",
                     busy, victim_valid, victim_way);
        end
        @(negedge clk);
        lk_valid    = 1'b1;
        lk_addr     = 32'h0000_0040;
        lk_inv_mask = 4'b0;
        @(negedge clk);
        lk_valid = 1'b0;
        v = victim_valid;
        w = victim_way;
        checks++;
        if (v !== 1'b1 || w !== 2'd0) begin
            errors++;
            $display("FAIL reset_lookup: vv=%b way=%0d expected 1 0", v, w);
        end
        @(negedge clk);
        checks++;
        if (victim_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: vv=%b expected 0", victim_valid);
        end
    endtask

    task automatic test_update;
        logic v;
        logic [1:0] w;
        // set 3: way0 -> root1 n1=1 -> victim 2
        access(3, 2'd0);
        lookup(3, 4'b0, v, w);
        checks++;
        if (v !== 1'b1 || w !== 2'd2) begin
            errors++;
            $display("FAIL s3_after0: vv=%b way=%0d expected 1 2", v, w);
        end
        // way1 -> root1 n1=0 n2=0 -> victim 2
        access(3, 2'd1);
        // way2 -> root0 n1=0 n2=1 -> walk low, n1=0 -> way 0
        access(3, 2'd2);
        lookup(3, 4'b0, v, w);
        checks++;
        if (w !== 2'd0) begin
            errors++;
            $display("FAIL s3_after012: way=%0d expected 0", w);
        end
        // way3 -> root0 n2=0 -> walk low, n1=0 -> way 0
        access(3, 2'd3);
        lookup(3, 4'b0, v, w);
        checks++;
        if (w !== 2'd0) begin
            errors++;
            $display("FAIL s3_after3: way=%0d expected 0", w);
        end
        // set 4: way2 then way0 -> root1 n1=1 n2=1 -> way 3
        access(4, 2'd2);
        lookup(4, 4'b0, v, w);
        checks++;
        if (w !== 2'd0) begin
            errors++;
            $display("FAIL s4_after2: way=%0d expected 0", w);
        end
        access(4, 2'd0);
        lookup(4, 4'b0, v, w);
        checks++;
        if (w !== 2'd3) begin
            errors++;
            $display("FAIL s4_after20: way=%0d expected 3", w);
        end
        lookup(4, 4'b0, v, w);
        checks++;
        if (w !== 2'd3) begin
            errors++;
            $display("FAIL s4_lookup_stable: way=%0d expected 3", w);
        end
    endtask

    task automatic test_inv_mask;
        logic v;
        logic [1:0] w;
        access(5, 2'd2);
        access(5, 2'd0);
        lookup(5, 4'b1010, v, w);
        checks++;
        if (v !== 1'b1 || w !== 2'd1) begin
            errors++;
            $display("FAIL mask_1010: vv=%b way=%0d expected 1 1", v, w);
        end
        lookup(5, 4'b0100, v, w);
        checks++;
        if (w !== 2'd2) begin
            errors++;
            $display("FAIL mask_0100: way=%0d expected 2", w);
        end
        lookup(5, 4'b0000, v, w);
        checks++;
        if (w !== 2'd3) begin
            errors++;
            $display("FAIL s5_tree_all1: way=%0d expected 3", w);
        end
    endtask

    task automatic test_bypass;
        logic v;
        logic [1:0] w;
        @(negedge clk);
        acc_valid   = 1'b1;
        acc_addr    = addr_of(7);
        acc_way     = 2'd0;
        lk_valid    = 1'b1;
        lk_addr     = addr_of(7);
        lk_inv_mask = 4'b0;
        @(negedge clk);
        acc_valid = 1'b0;
        lk_valid  = 1'b0;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd2) begin
            errors++;
            $display("FAIL bypass_same_set: vv=%b way=%0d expected 1 2",
                     victim_valid, victim_way);
        end
        @(negedge clk);
        acc_valid   = 1'b1;
        acc_addr    = addr_of(8);
        acc_way     = 2'd0;
        lk_valid    = 1'b1;
        lk_addr     = addr_of(9);
        lk_inv_mask = 4'b0;
        @(negedge clk);
        acc_valid = 1'b0;
        lk_valid  = 1'b0;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
            errors++;
            $display("FAIL diff_set_lookup: vv=%b way=%0d expected 1 0",
                     victim_valid, victim_way);
        end
        lookup(8, 4'b0, v, w);
        checks++;
        if (w !== 2'd2) begin
            errors++;
            $display("FAIL diff_set_update: way=%0d expected 2", w);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] w1;
        logic [1:0] w2;
        logic       v1;
        logic       v2;
        @(negedge clk);
        lk_valid    = 1'b1;
        lk_addr     = addr_of(3);
        lk_inv_mask = 4'b0;
        @(negedge clk);
        lk_addr = addr_of(5);
        v1 = victim_valid;
        w1 = victim_way;
        @(negedge clk);
        lk_valid = 1'b0;
        v2 = victim_valid;
        w2 = victim_way;
        checks++;
        if (v1 !== 1'b1 || w1 !== 2'd0 || v2 !== 1'b1 || w2 !== 2'd3) begin
            errors++;
            $display("FAIL back_to_back: %b/%0d %b/%0d expected 1/0 1/3",
                     v1, w1, v2, w2);
        end
    endtask

    task automatic test_flush;
        logic v;
        logic [1:0] w;
        int  busy_cnt;
        int  vv_bad;
        bit  seen_end;
        access(0, 2'd0);
        access(63, 2'd1);
        lookup(63, 4'b0, v, w);
        checks++;
        if (w !== 2'd2) begin
            errors++;
            $display("FAIL s63_populated: way=%0d expected 2", w);
        end
        // flush beats the access; the bypassed lookup must see the old tree
        @(negedge clk);
        flush_req   = 1'b1;
        acc_valid   = 1'b1;
        acc_addr    = addr_of(10);
        acc_way     = 2'd0;
        lk_valid    = 1'b1;
        lk_addr     = addr_of(10);
        lk_inv_mask = 4'b0;
        @(negedge clk);
        flush_req = 1'b0;
        acc_valid = 1'b0;
        lk_valid  = 1'b0;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd0) begin
            errors++;
            $display("FAIL flush_wins: vv=%b way=%0d expected 1 0",
                     victim_valid, victim_way);
        end
        busy_cnt = 0;
        vv_bad   = 0;
        seen_end = 1'b0;
        for (int c = 0; c < 200 && !seen_end; c++) begin
            if (busy) begin
                busy_cnt++;
                if (c > 0 && victim_valid) vv_bad++;
                acc_valid   = 1'b1;
                acc_addr    = addr_of(0);
                acc_way     = 2'd0;
                lk_valid    = 1'b1;
                lk_addr     = addr_of(0);
                flush_req   = 1'b1;
                @(negedge clk);
            end else begin
                seen_end = 1'b1;
                if (victim_valid) vv_bad++;
                acc_valid = 1'b0;
                lk_valid  = 1'b0;
                flush_req = 1'b0;
            end
        end
        acc_valid = 1'b0;
        lk_valid  = 1'b0;
        flush_req = 1'b0;
        checks++;
        if (!seen_end || busy_cnt != 64) begin
            errors++;
            $display("FAIL busy_length: cycles=%0d ended=%0b expected 64 1",
                     busy_cnt, seen_end);
        end
        checks++;
        if (vv_bad != 0) begin
            errors++;
            $display("FAIL lookup_during_busy: pulses=%0d expected 0", vv_bad);
        end
        lookup(0, 4'b0, v, w);
        checks++;
        if (v !== 1'b1 || w !== 2'd0) begin
            errors++;
            $display("FAIL s0_flushed: vv=%b way=%0d expected 1 0", v, w);
        end
        lookup(63, 4'b0, v, w);
        checks++;
        if (v !== 1'b1 || w !== 2'd0) begin
            errors++;
            $display("FAIL s63_flushed: vv=%b way=%0d expected 1 0", v, w);
        end
    endtask

    task automatic test_reset_mid_flush;
        logic v;
        logic [1:0] w;
        int   busy_left;
        access(63, 2'd1);
        access(62, 2'd0);
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || victim_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b vv=%b expected 0 0",
                     busy, victim_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        busy_left = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_left++;
        end
        checks++;
        if (busy_left != 0) begin
            errors++;
            $display("FAIL residual_busy: cycles=%0d expected 0", busy_left);
        end
        lookup(63, 4'b0, v, w);
        checks++;
        if (v !== 1'b1 || w !== 2'd0) begin
            errors++;
            $display("FAIL s63_after_reset: vv=%b way=%0d expected 1 0", v, w);
        end
        lookup(62, 4'b0, v, w);
        checks++;
        if (w !== 2'd0) begin
            errors++;
            $display("FAIL s62_after_reset: way=%0d expected 0", w);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        lk_valid    = 1'b0;
        lk_addr     = 32'b0;
        lk_inv_mask = 4'b0;
        acc_valid   = 1'b0;
        acc_addr    = 32'b0;
        acc_way     = 2'b0;
        flush_req   = 1'b0;
        test_reset();
        test_update();
        test_inv_mask();
        test_bypass();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
